// File: rtl/mlp_layer_sequencer_if.sv
// Handshake bundle between the MLP layer sequencer, the host, the fc layers and the output sink.
// The master modport is the environment side and the slave modport is the sequencer.
interface mlp_layer_sequencer_if #(
  parameter int NUM_LAYERS  = 5,
  parameter int FRAME_CNT_W = 16
);
  logic                   i_in_valid;
  logic                   o_in_ready;
  logic [NUM_LAYERS-1:0]  o_start;
  logic [NUM_LAYERS-1:0]  i_layer_busy;
  logic [NUM_LAYERS-1:0]  o_cim_busy;
  logic [NUM_LAYERS-1:0]  o_func_start;
  logic [NUM_LAYERS-1:0]  o_next_busy;
  logic [NUM_LAYERS-1:0]  i_func_done;
  logic                   o_out_valid;
  logic                   i_out_ready;
  logic [FRAME_CNT_W-1:0] o_frames_done;

  modport master (
    output i_in_valid, i_layer_busy, i_func_done, i_out_ready,
    input  o_in_ready, o_start, o_cim_busy, o_func_start, o_next_busy,
           o_out_valid, o_frames_done
  );

  modport slave (
    input  i_in_valid, i_layer_busy, i_func_done, i_out_ready,
    output o_in_ready, o_start, o_cim_busy, o_func_start, o_next_busy,
           o_out_valid, o_frames_done
  );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Schedules write / MVM / readout phases for a chain of fc CIM layers, one FSM per layer,
// with handoff to a layer only when it is empty so frames pipeline down the chain.
module mlp_layer_sequencer #(
  parameter int NUM_LAYERS  = 5,
  parameter int CIM_LATENCY = 16,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  mlp_layer_sequencer_if.slave   bus
);
  localparam int LAST  = NUM_LAYERS - 1;
  localparam int CNT_W = (CIM_LATENCY > 1) ? $clog2(CIM_LATENCY) : 1;

  localparam logic [3:0] S_EMPTY = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_WR_HI = 4'd2;
  localparam logic [3:0] S_WR_LO = 4'd3;
  localparam logic [3:0] S_MVM   = 4'd4;
  localparam logic [3:0] S_HOLD  = 4'd5;
  localparam logic [3:0] S_FUNC  = 4'd6;
  localparam logic [3:0] S_DRAIN = 4'd7;
  localparam logic [3:0] S_OUT   = 4'd8;

  logic [3:0]             state_q [NUM_LAYERS];
  logic [3:0]             state_d [NUM_LAYERS];
  logic [CNT_W-1:0]       cnt_q   [NUM_LAYERS];
  logic [CNT_W-1:0]       cnt_d   [NUM_LAYERS];
  logic [FRAME_CNT_W-1:0] frames_q, frames_d;

  logic [NUM_LAYERS-1:0]  empty, load, drain_done, next_busy;

  // Load events: host for layer 0, predecessor's drain-done cycle for the rest.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    empty      = '0;
    drain_done = '0;
    load       = '0;
    next_busy  = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      empty[l]      = (state_q[l] == S_EMPTY);
      drain_done[l] = (state_q[l] == S_DRAIN) && bus.i_func_done[l];
    end
    load[0]         = bus.i_in_valid && empty[0];
    next_busy[LAST] = ~bus.i_out_ready;
    for (int l = 1; l < NUM_LAYERS; l++) begin
      load[l]        = drain_done[l-1];
      next_busy[l-1] = ~empty[l];
    end
  end

  always_comb begin
    frames_d = frames_q;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      state_d[l] = state_q[l];
      cnt_d[l]   = cnt_q[l];
      case (state_q[l])
        S_EMPTY: if (load[l]) state_d[l] = S_START;
        S_START: state_d[l] = S_WR_HI;
        S_WR_HI: if (bus.i_layer_busy[l]) state_d[l] = S_WR_LO;
        S_WR_LO: if (!bus.i_layer_busy[l]) begin
          cnt_d[l]   = CNT_W'(CIM_LATENCY - 1);
          state_d[l] = S_MVM;
        end
        S_MVM: begin
          if (cnt_q[l] == '0) state_d[l] = S_HOLD;
          else                cnt_d[l]   = cnt_q[l] - 1'b1;
        end
        // Successor occupancy is taken from registered state, so a successor that
        // empties this cycle is only seen next cycle.
        S_HOLD:  if (!next_busy[l]) state_d[l] = S_FUNC;
        S_FUNC:  state_d[l] = S_DRAIN;
        S_DRAIN: if (bus.i_func_done[l]) state_d[l] = (l == LAST) ? S_OUT : S_EMPTY;
        S_OUT: if (bus.i_out_ready) begin
          state_d[l] = S_EMPTY;
          frames_d   = frames_q + 1'b1;
        end
        default: state_d[l] = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NUM_LAYERS; l++) begin
        state_q[l] <= S_EMPTY;
        cnt_q[l]   <= '0;
      end
      frames_q <= '0;
    end else begin
      // NOTE: non-blocking updates let every layer read the others' pre-edge state, independent of loop order.
      for (int l = 0; l < NUM_LAYERS; l++) begin
        state_q[l] <= state_d[l];
        cnt_q[l]   <= cnt_d[l];
      end
      frames_q <= frames_d;
    end
  end

  // Outputs decode state registers directly, so reset clears them without waiting for a clock.
  always_comb begin
    bus.o_start      = '0;
    bus.o_cim_busy   = '0;
    bus.o_func_start = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      bus.o_start[l]      = (state_q[l] == S_START);
      bus.o_cim_busy[l]   = (state_q[l] == S_MVM);
      bus.o_func_start[l] = (state_q[l] == S_FUNC);
    end
    bus.o_in_ready    = empty[0];
    bus.o_next_busy   = next_busy;
    bus.o_out_valid   = (state_q[LAST] == S_OUT);
    bus.o_frames_done = frames_q;
  end
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Self-checking bench: fc-layer responders driven from the sequencer's pulses, and a
// per-frame timeline model predicting every output cycle by cycle.
module tb_mlp_layer_sequencer;
  localparam int NL = 5;
  localparam int CL = 4;
  localparam int FW = 2;

  logic clk = 1'b0;
  logic rst;

  mlp_layer_sequencer_if #(.NUM_LAYERS(NL), .FRAME_CNT_W(FW)) bus ();

  mlp_layer_sequencer #(.NUM_LAYERS(NL), .CIM_LATENCY(CL), .FRAME_CNT_W(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc;

  // Timeline model: per layer, whether it holds a frame and the cycles at which that
  // frame's events happened or are due (-1 = not yet).
  bit m_occ   [NL];
  int m_start [NL];
  int m_hi    [NL];
  int m_mlo   [NL];
  int m_mhi   [NL];
  int m_func  [NL];
  int m_out   [NL];
  int m_frames;

  // fc-layer responders
  int busy_on [NL];
  int busy_off[NL];
  int done_at [NL];
  int cim_cnt [NL];
  int busy_min, busy_max, done_min, done_max;
  bit in_valid_drv, out_ready_drv;
  logic [NL-1:0] spur_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m_occ[l] = 1'b0;
      m_start[l] = -1; m_hi[l] = -1; m_mlo[l] = -1; m_mhi[l] = -1;
      m_func[l] = -1;  m_out[l] = -1;
      busy_on[l] = 0;  busy_off[l] = 0; done_at[l] = -1; cim_cnt[l] = 0;
    end
    m_frames = 0;
  endtask

  function automatic bit model_idle();
    bit idle = 1'b1;
    for (int l = 0; l < NL; l++) if (m_occ[l]) idle = 1'b0;
    return idle;
  endfunction

  task automatic drive_inputs();
    for (int l = 0; l < NL; l++) begin
      bus.i_layer_busy[l] = (cyc >= busy_on[l]) && (cyc < busy_off[l]);
      bus.i_func_done[l]  = (cyc == done_at[l]) || spur_done[l];
    end
    bus.i_in_valid  = in_valid_drv;
    bus.i_out_ready = out_ready_drv;
  endtask

  task automatic check_outputs();
    logic [NL-1:0] es, ec, ef, enb;
    logic [FW-1:0] efr;
    for (int l = 0; l < NL; l++) begin
      es[l]  = m_occ[l] && (m_start[l] == cyc);
      ec[l]  = m_occ[l] && (m_mlo[l] >= 0) && (cyc >= m_mlo[l]) && (cyc <= m_mhi[l]);
      ef[l]  = m_occ[l] && (m_func[l] == cyc);
      if (l < NL - 1) enb[l] = m_occ[l+1];
      else            enb[l] = !out_ready_drv;
    end
    efr = m_frames[FW-1:0];
    check("o_start",       32'(bus.o_start),       32'(es));
    check("o_cim_busy",    32'(bus.o_cim_busy),    32'(ec));
    check("o_func_start",  32'(bus.o_func_start),  32'(ef));
    check("o_next_busy",   32'(bus.o_next_busy),   32'(enb));
    check("o_in_ready",    32'(bus.o_in_ready),    32'(!m_occ[0]));
    check("o_out_valid",   32'(bus.o_out_valid),   32'(m_occ[NL-1] && m_out[NL-1] >= 0 && cyc >= m_out[NL-1]));
    check("o_frames_done", 32'(bus.o_frames_done), 32'(efr));
  endtask

  // Advance the timeline across the edge ending cycle cyc, using this cycle's inputs.
  task automatic model_step();
    bit ld[NL];
    bit ex[NL];
    bit free_succ;
    for (int l = 0; l < NL; l++) begin ld[l] = 1'b0; ex[l] = 1'b0; end
    ld[0] = bus.i_in_valid && !m_occ[0];
    for (int l = 0; l < NL; l++) begin
      if (!m_occ[l]) continue;
      if (m_mlo[l] < 0) begin
        if (cyc > m_start[l]) begin
          if (m_hi[l] < 0) begin
            if (bus.i_layer_busy[l]) m_hi[l] = cyc;
          end else if (cyc > m_hi[l] && !bus.i_layer_busy[l]) begin
            m_mlo[l] = cyc + 1;
            m_mhi[l] = cyc + CL;
          end
        end
      end else if (m_func[l] < 0) begin
        if (cyc > m_mhi[l]) begin
          if (l == NL - 1) free_succ = bus.i_out_ready;
          else             free_succ = !m_occ[l+1];
          if (free_succ) m_func[l] = cyc + 1;
        end
      end else if (m_out[l] < 0) begin
        if (cyc > m_func[l] && bus.i_func_done[l]) begin
          if (l == NL - 1) m_out[l] = cyc + 1;
          else begin ex[l] = 1'b1; ld[l+1] = 1'b1; end
        end
      end else if (cyc >= m_out[l] && bus.i_out_ready) begin
        ex[l] = 1'b1;
        m_frames++;
      end
    end
    for (int l = 0; l < NL; l++) begin
      if (ex[l]) m_occ[l] = 1'b0;
      if (ld[l]) begin
        m_occ[l] = 1'b1;
        m_start[l] = cyc + 1;
        m_hi[l] = -1; m_mlo[l] = -1; m_mhi[l] = -1; m_func[l] = -1; m_out[l] = -1;
      end
    end
  endtask

  task automatic run_cycle();
    drive_inputs();
    #1;
    check_outputs();
    for (int l = 0; l < NL; l++) begin
      if (bus.o_cim_busy[l]) cim_cnt[l]++;
      if (bus.o_start[l]) begin
        busy_on[l]  = cyc + 3;
        busy_off[l] = cyc + 3 + int'($urandom_range(busy_max, busy_min));
      end
      if (bus.o_func_start[l]) done_at[l] = cyc + int'($urandom_range(done_max, done_min));
    end
    model_step();
    spur_done = '0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while (!model_idle() && n < budget) begin
      run_cycle();
      n++;
    end
    if (!model_idle()) begin
      checks++;
      errors++;
      $error("FAIL timeout_%s cyc=%0d got=busy exp=idle", tag, cyc);
    end
  endtask

  task automatic wait_for_cim(input string tag, input int layer, input int budget);
    int n = 0;
    while (bus.o_cim_busy[layer] !== 1'b1 && n < budget) begin
      run_cycle();
      n++;
    end
    if (bus.o_cim_busy[layer] !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL timeout_%s cyc=%0d got=0 exp=1", tag, cyc);
    end
  endtask

  initial begin
    int wrap_seq[5] = '{1, 2, 3, 0, 1};
    int frames_before;

    rst = 1'b1;
    cyc = 0;
    in_valid_drv = 1'b0;
    out_ready_drv = 1'b0;
    spur_done = '0;
    model_reset();
    drive_inputs();
    #12;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // Single frame, fixed responder timing.
    busy_min = 3; busy_max = 3; done_min = 5; done_max = 5;
    out_ready_drv = 1'b1;
    in_valid_drv = 1'b1;
    run_cycle();
    in_valid_drv = 1'b0;
    check("start0_latency", 32'(bus.o_start[0]), 32'd1);
    run_until_idle("single", 400);
    for (int l = 0; l < NL; l++) check("cim_len", 32'(cim_cnt[l]), 32'(CL));
    check("single_frames", 32'(bus.o_frames_done), 32'd1);
    check("single_in_ready", 32'(bus.o_in_ready), 32'd1);

    // Spurious host valid during MVM and func_done to an empty layer.
    busy_min = 1; busy_max = 3; done_min = 1; done_max = 5;
    in_valid_drv = 1'b1;
    run_cycle();
    in_valid_drv = 1'b0;
    wait_for_cim("spur", 0, 100);
    in_valid_drv = 1'b1;
    spur_done = 5'b01000;
    run_cycle();
    in_valid_drv = 1'b0;
    check("spur_no_start", 32'(bus.o_start), 32'd0);
    check("spur_in_ready", 32'(bus.o_in_ready), 32'd0);
    run_until_idle("spur", 400);

    // Pipelining: new frame enters layer 0 while layer 1 computes.
    in_valid_drv = 1'b1;
    run_cycle();
    in_valid_drv = 1'b0;
    wait_for_cim("pipe", 1, 200);
    in_valid_drv = 1'b1;
    run_cycle();
    in_valid_drv = 1'b0;
    check("pipe_start0", 32'(bus.o_start[0]), 32'd1);
    check("pipe_cim1", 32'(bus.o_cim_busy[1]), 32'd1);
    run_until_idle("pipe", 600);

    // Backpressure: sink stalls until every layer holds a frame.
    frames_before = m_frames;
    out_ready_drv = 1'b0;
    in_valid_drv = 1'b1;
    repeat (300) run_cycle();
    check("bp_in_ready", 32'(bus.o_in_ready), 32'd0);
    check("bp_next_busy", 32'(bus.o_next_busy), 32'h1f);
    check("bp_no_func", 32'(bus.o_func_start), 32'd0);
    in_valid_drv = 1'b0;
    out_ready_drv = 1'b1;
    run_until_idle("bp", 1500);
    check("bp_frames", 32'(bus.o_frames_done), 32'((frames_before + 5) % (1 << FW)));

    // Random traffic with random responder timing and sink stalls.
    busy_min = 1; busy_max = 4; done_min = 1; done_max = 6;
    repeat (600) begin
      in_valid_drv = 1'($urandom_range(1, 0));
      out_ready_drv = ($urandom_range(3, 0) != 0);
      run_cycle();
    end
    in_valid_drv = 1'b0;
    out_ready_drv = 1'b1;
    run_until_idle("rand", 1500);

    // Reset while layer 2 is in MVM.
    in_valid_drv = 1'b1;
    wait_for_cim("rst", 2, 400);
    in_valid_drv = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_start", 32'(bus.o_start), 32'd0);
    check("rst_cim", 32'(bus.o_cim_busy), 32'd0);
    check("rst_func", 32'(bus.o_func_start), 32'd0);
    check("rst_out_valid", 32'(bus.o_out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.o_in_ready), 32'd1);
    check("rst_frames", 32'(bus.o_frames_done), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    repeat (30) run_cycle();
    check("post_rst_frames", 32'(bus.o_frames_done), 32'd0);

    // Counter wrap with a 2-bit frame counter.
    for (int i = 0; i < 5; i++) begin
      in_valid_drv = 1'b1;
      run_cycle();
      in_valid_drv = 1'b0;
      run_until_idle("wrap", 400);
      check("wrap_seq", 32'(bus.o_frames_done), 32'(wrap_seq[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mlp_layer_sequencer.md
Name: mlp_layer_sequencer

Overview:
- Central scheduler for a chain of NUM_LAYERS fully-connected CIM layers in an MLP top.
- Per layer, sequences three phases:
  - input-buffer write into crossbar rows (start handshake);
  - crossbar MVM, with analog latency modelled by a counter driving the layer's cim-busy input;
  - function/activation readout into the next layer's input buffer.
- Provides inter-layer backpressure: a layer may only hand off when its successor is empty.
- Frames pipeline across layers, so several layers can be active on different frames at once.

Parameters:
- NUM_LAYERS, 5, number of chained fc layers (≥1).
- CIM_LATENCY, 16, cycles o_cim_busy[l] stays high per MVM (≥1).
- FRAME_CNT_W, 16, width of completed-frame counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_in_valid  in  1  host: layer-0 input buffer loaded with one frame.
- o_in_ready  out  1  layer 0 is EMPTY; host may load and pulse i_in_valid.
- o_start  out  NUM_LAYERS  one-cycle pulse per layer, to fc layer i_start.
- i_layer_busy  in  NUM_LAYERS  fc layer o_busy (crossbar write in progress).
- o_cim_busy  out  NUM_LAYERS  crossbar MVM in progress, to fc layer i_cim_busy.
- o_func_start  out  NUM_LAYERS  one-cycle pulse, to fc layer i_func_start.
- o_next_busy  out  NUM_LAYERS  successor not EMPTY, to fc layer i_next_busy. For the last layer this is ~i_out_ready.
- i_func_done  in  NUM_LAYERS  one-cycle pulse: layer finished emitting outputs.
- o_out_valid  out  1  last layer holds a finished frame.
- i_out_ready  in  1  sink accepts the finished frame.
- o_frames_done  out  FRAME_CNT_W  frames accepted at output; wraps modulo 2^FRAME_CNT_W.

Behaviour:
- Reset: every layer FSM goes to EMPTY. All outputs are 0 except o_in_ready=1. o_frames_done=0 and latency counters=0.
- Reset mid-operation: all in-flight frames are discarded and any pulse in progress is aborted immediately. o_cim_busy drops asynchronously.
- One registered FSM per layer l. States and transitions:
  - EMPTY: leave when a load event arrives. For l=0 the event is i_in_valid && o_in_ready. For l>0 it is handoff from layer l-1. Next state is START.
  - START: o_start[l]=1 for exactly one cycle. Go to WR_HI.
  - WR_HI: wait for i_layer_busy[l]=1, then go to WR_LO.
  - WR_LO: wait for i_layer_busy[l]=0. Then load the counter with CIM_LATENCY-1 and go to MVM.
  - MVM: o_cim_busy[l]=1. Counter decrements each cycle. At 0 go to HOLD. o_cim_busy is high exactly CIM_LATENCY cycles.
  - HOLD: wait until the successor is EMPTY. For the last layer, wait for i_out_ready instead. Then go to FUNC.
  - FUNC: o_func_start[l]=1 for one cycle. Go to DRAIN.
  - DRAIN: wait for i_func_done[l].
    - l < NUM_LAYERS-1: the done cycle issues a load event to layer l+1, and layer l goes to EMPTY next cycle.
    - Last layer: go to OUT.
  - OUT (last layer only): o_out_valid=1. When i_out_ready=1, o_frames_done increments and the FSM goes to EMPTY.
- o_in_ready = (state[0]==EMPTY), combinational from state.
- o_next_busy[l] = (state[l+1]!=EMPTY). For the last layer it is ~i_out_ready. Both are combinational.
- Latency:
  - i_in_valid at cycle 0 gives o_start[0] at cycle 1.
  - i_func_done[l] at cycle t gives o_start[l+1] at cycle t+1.
- Successor reservation: the successor becomes non-EMPTY only at the handoff. While layer l is in DRAIN, layer l+1 is already reserved because HOLD waited for it to be EMPTY. No other layer can load it, so handoff never collides.
- Simultaneous events:
  - If layer l+1 goes EMPTY in the same cycle that layer l is in HOLD, layer l sees EMPTY the next cycle. There is no combinational bypass.
  - Handoff into layer l+1 and layer l+1's own exit in the same cycle cannot occur, by construction of HOLD.
- Spurious inputs are ignored: i_in_valid while o_in_ready=0, and i_func_done[l] outside DRAIN.
- i_layer_busy that never rises leaves the FSM in WR_HI indefinitely; no timeout.
- Pipelining: independent layer FSMs let layer l process frame n+1 while layer l+1 processes frame n.

Test Plan:
- Single frame, NUM_LAYERS=5, CIM_LATENCY=4. i_in_valid at cycle 0; each layer's busy is high 3 cycles after its start; each func_done comes 5 cycles after its func_start; i_out_ready=1.
  - Required: o_start[0] at cycle 1.
  - Required: every o_cim_busy high exactly 4 cycles.
  - Required: o_start[l+1] one cycle after func_done[l].
  - Required: o_frames_done=1; o_in_ready high again after layer 0 drains.
- Backpressure: hold i_out_ready=0 and push frames until the chain is full.
  - Required: the last layer parks in HOLD; every layer ends in HOLD with no further o_func_start; o_in_ready=0.
  - Then raise i_out_ready: frames drain in order and o_frames_done counts to 5.
- Pipelining: a second i_in_valid after layer 0 returns to EMPTY while layer 1 is still in MVM.
  - Required: layer 0 o_start fires while o_cim_busy[1]=1.
- Reset mid-MVM: assert rst while o_cim_busy[2]=1.
  - Required: o_cim_busy and all pulses 0 immediately; o_in_ready=1; o_frames_done=0; no output after rst is released.
- Spurious inputs: i_in_valid while layer 0 is in MVM, and i_func_done[3] while layer 3 is EMPTY.
  - Required: no state change and no pulses.
- Counter wrap: FRAME_CNT_W=2, complete 5 frames.
  - Required: o_frames_done sequence 1,2,3,0,1.
